// File: rtl/freq_gate_sched_pkg.sv
// freq_gate_sched_pkg: shared state encoding, range constants and gate-length helper
package freq_gate_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_LATCH,
        S_EVAL
    } state_t;

    localparam int RANGE_W    = 2;
    localparam int NUM_RANGES = 4;

    // Gate length for range r; each range shortens the gate by 2**shift.
    function automatic int gate_len(input int r, input int gmax, input int shift);
        return gmax >> (shift * r);
    endfunction

endpackage

// File: rtl/freq_gate_timer.sv
// freq_gate_timer: loadable gate down-counter, done flags the last enabled cycle
module freq_gate_timer #(
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load the gate length, then count down once per gate cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = i_dec && (r_cnt <= W'(1));

endmodule

// File: rtl/freq_gate_sched.sv
// freq_gate_sched: clear/gate/latch/evaluate sequencer for one meter channel; FREQ_GATE_AUTORANGE_EN enables auto-ranging
module freq_gate_sched
    import freq_gate_sched_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_MAX    = 64,
    parameter int RANGE_SHIFT = 2,
    parameter int LOW_THRESH  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_run,
    input  logic [RANGE_W-1:0] i_range_sel,
    input  logic [CNT_W-1:0]   i_cnt_value,
    input  logic               i_cnt_ovf,
    output logic               o_cnt_clr,
    output logic               o_cnt_en,
    output logic               o_latch,
    output logic [CNT_W-1:0]   o_freq_out,
    output logic [RANGE_W-1:0] o_range_out,
    output logic               o_meas_valid,
    output logic               o_busy
);

    localparam int GW = $clog2(GATE_MAX + 1);

    state_t             r_state, w_next;
    logic [RANGE_W-1:0] r_range, w_range_nxt;
    logic [CNT_W-1:0]   r_freq;
    logic [RANGE_W-1:0] r_range_out;
    logic               r_valid;
    logic               w_done;
    logic [GW-1:0]      w_gate_tbl [NUM_RANGES];

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_tbl
        assign w_gate_tbl[g] = GW'(gate_len(g, GATE_MAX, RANGE_SHIFT));
    end

    freq_gate_timer #(.W(GW)) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (r_state == S_CLEAR),
        .i_load_val (w_gate_tbl[r_range]),
        .i_dec      (r_state == S_GATE),
        .o_done     (w_done)
    );

    // Next-state sequencing; a started measurement always runs through EVAL.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_run ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = S_GATE;
            S_GATE:  w_next = w_done ? S_LATCH : S_GATE;
            S_LATCH: w_next = S_EVAL;
            S_EVAL:  w_next = i_run ? S_CLEAR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Active range for the next gate: tracks range_sel when idle, adapts to the result in EVAL.
    always_comb begin
        w_range_nxt = r_range;
`ifdef FREQ_GATE_AUTORANGE_EN
        if (r_state == S_IDLE)
            w_range_nxt = i_range_sel;
        else if (r_state == S_EVAL) begin
            if (i_cnt_ovf && r_range != RANGE_W'(NUM_RANGES - 1))
                w_range_nxt = r_range + 1'b1;
            else if (!i_cnt_ovf && i_cnt_value < CNT_W'(LOW_THRESH) && r_range != '0)
                w_range_nxt = r_range - 1'b1;
        end
`else
        if (r_state == S_IDLE || r_state == S_EVAL)
            w_range_nxt = i_range_sel;
`endif
    end

    // State and active-range registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_range <= i_range_sel;
        end else begin
            r_state <= w_next;
            r_range <= w_range_nxt;
        end
    end

    // Result capture: an overflowed count is dropped and the old reading kept.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_freq      <= '0;
            r_range_out <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= (r_state == S_EVAL) && !i_cnt_ovf;
            if (r_state == S_EVAL && !i_cnt_ovf) begin
                r_freq      <= i_cnt_value;
                r_range_out <= r_range;
            end
        end
    end

    assign o_cnt_clr    = (r_state == S_CLEAR);
    assign o_cnt_en     = (r_state == S_GATE);
    assign o_latch      = (r_state == S_LATCH);
    assign o_busy       = (r_state != S_IDLE);
    assign o_freq_out   = r_freq;
    assign o_range_out  = r_range_out;
    assign o_meas_valid = r_valid;

endmodule

// File: tb/tb_freq_gate_sched.sv
// tb_freq_gate_sched: table-driven and sequence checks of the gate scheduler (default gates 64/16/4/1)
module tb_freq_gate_sched;

`ifdef FREQ_GATE_AUTORANGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [1:0]  range_sel;
    logic [15:0] cnt_value;
    logic        cnt_ovf;
    logic        cnt_clr, cnt_en, latch, meas_valid, busy;
    logic [15:0] freq_out;
    logic [1:0]  range_out;

    int checks = 0;
    int passes = 0;
    bit mon_en = 1'b0;

    int          gate [4];
    bit          val  [4];
    int          vt   [4];
    logic [15:0] fq   [4];
    logic [1:0]  rg   [4];

    typedef struct {
        logic [1:0]  rs;
        logic [15:0] cv;
        logic        ovf;
        int          gate;
        logic        valid;
        logic [15:0] freq;
        logic [1:0]  rng;
    } vec_t;

    vec_t v [6];

    freq_gate_sched dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_run        (run),
        .i_range_sel  (range_sel),
        .i_cnt_value  (cnt_value),
        .i_cnt_ovf    (cnt_ovf),
        .o_cnt_clr    (cnt_clr),
        .o_cnt_en     (cnt_en),
        .o_latch      (latch),
        .o_freq_out   (freq_out),
        .o_range_out  (range_out),
        .o_meas_valid (meas_valid),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timeout got busy expected idle", name);
    endtask

    always @(negedge clk)
        if (mon_en)
            chk("mutex", longint'(int'(cnt_clr) + int'(cnt_en) + int'(latch) <= 1), 1);

    task automatic single(input vec_t t, input int n);
        int nclr, nen, nlat, vat, k;
        bit seen;
        nclr = 0; nen = 0; nlat = 0; vat = -1; seen = 1'b0;
        @(posedge clk); #1;
        range_sel = t.rs; cnt_value = t.cv; cnt_ovf = t.ovf; run = 1'b1;
        for (k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (k == 1) run = 1'b0;
            nclr += int'(cnt_clr);
            nen  += int'(cnt_en);
            nlat += int'(latch);
            if (meas_valid) begin seen = 1'b1; vat = k; end
            if (!busy) break;
        end
        if (k > 400) timeout($sformatf("v%0d_done", n));
        chk($sformatf("v%0d_clr", n), nclr, 1);
        chk($sformatf("v%0d_en", n), nen, t.gate);
        chk($sformatf("v%0d_latch", n), nlat, 1);
        chk($sformatf("v%0d_valid", n), seen, t.valid);
        if (t.valid) chk($sformatf("v%0d_latency", n), vat, t.gate + 4);
        chk($sformatf("v%0d_freq", n), freq_out, t.freq);
        chk($sformatf("v%0d_range", n), range_out, t.rng);
    endtask

    task automatic cont(input logic [1:0] rs, input logic [15:0] cv1, input logic ovf1,
                        input logic [15:0] cv2, input logic ovf2, input bit drop_gate, input string name);
        int idx, k;
        idx = 0;
        for (int i = 0; i < 4; i++) begin gate[i] = 0; val[i] = 0; vt[i] = -1; fq[i] = '0; rg[i] = '0; end
        @(posedge clk); #1;
        range_sel = rs; cnt_value = cv1; cnt_ovf = ovf1; run = 1'b1;
        for (k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            if (meas_valid && idx > 0) begin val[idx] = 1'b1; vt[idx] = k; fq[idx] = freq_out; rg[idx] = range_out; end
            if (cnt_clr && idx < 3) begin
                idx++;
                if (idx == 2) begin cnt_value = cv2; cnt_ovf = ovf2; end
            end
            if (cnt_en) gate[idx] += 1;
            if (idx == 2 && run && (drop_gate ? cnt_en : latch)) run = 1'b0;
            if (!busy) break;
        end
        if (k > 600) begin timeout({name, "_done"}); run = 1'b0; end
        chk({name, "_count"}, idx, 2);
    endtask

    initial begin
        v[0] = '{2'd1, 16'd100,   1'b0, 16, 1'b1, 16'd100,   2'd1};
        v[1] = '{2'd0, 16'd1234,  1'b0, 64, 1'b1, 16'd1234,  2'd0};
        v[2] = '{2'd2, 16'd7,     1'b0, 4,  1'b1, 16'd7,     2'd2};
        v[3] = '{2'd3, 16'hFFFF,  1'b0, 1,  1'b1, 16'hFFFF,  2'd3};
        v[4] = '{2'd2, 16'd55,    1'b1, 4,  1'b0, 16'hFFFF,  2'd3};
        v[5] = '{2'd0, 16'd0,     1'b0, 64, 1'b1, 16'd0,     2'd0};

        reset_n = 1'b0; run = 1'b0; range_sel = 2'd0; cnt_value = '0; cnt_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_latch", latch, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_freq", freq_out, 0);
        chk("rst_range", range_out, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) single(v[i], i);

        cont(2'd2, 16'd100, 1'b0, 16'd100, 1'b0, 1'b1, "cont");
        chk("cont_gate1", gate[1], 4);
        chk("cont_gate2", gate[2], 4);
        chk("cont_val1", val[1], 1);
        chk("cont_val2", val[2], 1);
        chk("cont_latency", vt[1], 8);
        chk("cont_period", vt[2] - vt[1], 7);
        chk("cont_freq", fq[2], 100);
        chk("cont_idle", busy, 0);

        cont(2'd0, 16'd0, 1'b1, 16'd500, 1'b0, 1'b0, "ovf");
        chk("ovf_gate1", gate[1], 64);
        chk("ovf_val1", val[1], 0);
        chk("ovf_gate2", gate[2], AUTO ? 16 : 64);
        chk("ovf_val2", val[2], 1);
        chk("ovf_freq2", fq[2], 500);
        chk("ovf_range2", rg[2], AUTO ? 1 : 0);

        cont(2'd2, 16'd3, 1'b0, 16'd3, 1'b0, 1'b0, "low");
        chk("low_val1", val[1], 1);
        chk("low_freq1", fq[1], 3);
        chk("low_range1", rg[1], 2);
        chk("low_gate2", gate[2], AUTO ? 16 : 4);
        chk("low_range2", rg[2], AUTO ? 1 : 2);

        cont(2'd3, 16'd9, 1'b1, 16'd9, 1'b1, 1'b0, "top");
        chk("top_gate1", gate[1], 1);
        chk("top_gate2", gate[2], 1);
        chk("top_val1", val[1], 0);
        chk("top_val2", val[2], 0);
        chk("top_freq", freq_out, 3);

        @(posedge clk); #1;
        range_sel = 2'd0; run = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_in_gate", cnt_en, 1);
        reset_n = 1'b0; run = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("mid_en", cnt_en, 0);
        chk("mid_busy", busy, 0);
        chk("mid_freq", freq_out, 0);
        chk("mid_range", range_out, 0);
        chk("mid_valid", meas_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_stays_idle", busy, 0);

        single(v[0], 6);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
